// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: register-file codes and data widths.
// Build option WB_FIXED_PRIO_EN (see wb_rr_arb) does not change anything in this package.
`ifndef FCU_DDATA_WIDTH
`define FCU_DDATA_WIDTH 64
`endif
`ifndef FCU_VDATA_WIDTH
`define FCU_VDATA_WIDTH 128
`endif

package wb_port_arbiter_pkg;

   typedef enum logic [1:0] {
      WB_FILE_GPR  = 2'b00,
      WB_FILE_FGPR = 2'b01,
      WB_FILE_VGPR = 2'b10,
      WB_FILE_RSVD = 2'b11
   } wb_file_e;

   localparam int WB_DW    = `FCU_DDATA_WIDTH;
   localparam int WB_VW    = `FCU_VDATA_WIDTH;
   localparam int WB_IDX_W = 5;

   // One-hot decode of a file code: bit0 GPR, bit1 FGPR, bit2 VGPR, bit3 reserved.
   function automatic logic [3:0] wb_file_decode(input logic [1:0] code);
      logic [3:0] oh;
      case (code)
         WB_FILE_GPR:  oh = 4'b0001;
         WB_FILE_FGPR: oh = 4'b0010;
         WB_FILE_VGPR: oh = 4'b0100;
         WB_FILE_RSVD: oh = 4'b1000;
         default:      oh = 4'b1000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Per-register-file arbiter: request vector in, one-hot grant out.
// Round-robin by default; `define WB_FIXED_PRIO_EN for fixed lowest-index priority.
module wb_rr_arb #(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] gidx_s;
   logic          hit_s;

`ifdef WB_FIXED_PRIO_EN

   // Fixed priority: the lowest-numbered requesting port wins.
   always_comb begin
      grant  = '0;
      hit_s  = 1'b0;
      gidx_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!hit_s && req[k]) begin
            grant[k] = 1'b1;
            hit_s    = 1'b1;
            gidx_s   = PW'(k);
         end else begin
            grant[k] = grant[k];
         end
      end
   end

`else

   localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

   logic [PW-1:0] ptr_r;
   logic [PW-1:0] ptr_next_s;
   logic [PW-1:0] idx_s;
   int            pos_s;

   // Round-robin search starting at the pointer, wrapping at NREQ.
   always_comb begin
      grant  = '0;
      hit_s  = 1'b0;
      gidx_s = '0;
      pos_s  = 0;
      idx_s  = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos_s = int'(ptr_r) + k;
         if (pos_s >= NREQ) begin
            pos_s = pos_s - NREQ;
         end else begin
            pos_s = pos_s;
         end
         idx_s = PW'(pos_s);
         if (!hit_s && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            hit_s        = 1'b1;
            gidx_s       = idx_s;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // Pointer moves to the port just after the winner.
   always_comb begin
      if (gidx_s == LAST) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = gidx_s + PW'(1);
      end
   end

   // Pointer register; holds when nothing is granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r <= '0;
      end else if (hit_s) begin
         ptr_r <= ptr_next_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the GPR/FGPR/VGPR write ports among NREQ writeback requesters, one arbiter per file.
// `define WB_FIXED_PRIO_EN selects fixed priority inside wb_rr_arb instead of round-robin.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = WB_DW,
   parameter int VW   = WB_VW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_file,
   input  logic [5*NREQ-1:0]    req_index,
   input  logic [VW*NREQ-1:0]   req_data,
   output logic                 gpr_write,
   output logic [4:0]           rd_index,
   output logic [DW-1:0]        data_rd,
   output logic                 fgpr_write,
   output logic [4:0]           fd_index,
   output logic [DW-1:0]        data_fd,
   output logic                 vgpr_write,
   output logic [4:0]           vd_index,
   output logic [VW-1:0]        data_vd,
   output logic                 bad_req
);

   logic [NREQ-1:0] cand_gpr_s, cand_fgpr_s, cand_vgpr_s, rsvd_s;
   logic [NREQ-1:0] grant_gpr_s, grant_fgpr_s, grant_vgpr_s;
   logic [3:0]      dec_s;

   logic [4:0]      gpr_idx_s, fgpr_idx_s, vgpr_idx_s;
   logic [DW-1:0]   gpr_data_s, fgpr_data_s;
   logic [VW-1:0]   vgpr_data_s;

   // Split valid requests into per-file candidate sets.
   always_comb begin
      cand_gpr_s  = '0;
      cand_fgpr_s = '0;
      cand_vgpr_s = '0;
      rsvd_s      = '0;
      dec_s       = 4'b0000;
      for (int i = 0; i < NREQ; i++) begin
         dec_s          = wb_file_decode(req_file[2*i +: 2]);
         cand_gpr_s[i]  = req_valid[i] & dec_s[0];
         cand_fgpr_s[i] = req_valid[i] & dec_s[1];
         cand_vgpr_s[i] = req_valid[i] & dec_s[2];
         rsvd_s[i]      = req_valid[i] & dec_s[3];
      end
   end

   wb_rr_arb #(.NREQ(NREQ)) u_arb_gpr (
      .clk   (clk),
      .rst   (rst),
      .req   (cand_gpr_s),
      .grant (grant_gpr_s)
   );

   wb_rr_arb #(.NREQ(NREQ)) u_arb_fgpr (
      .clk   (clk),
      .rst   (rst),
      .req   (cand_fgpr_s),
      .grant (grant_fgpr_s)
   );

   wb_rr_arb #(.NREQ(NREQ)) u_arb_vgpr (
      .clk   (clk),
      .rst   (rst),
      .req   (cand_vgpr_s),
      .grant (grant_vgpr_s)
   );

   // Reserved-code requests are swallowed immediately so they never block the requester.
   assign req_ready = grant_gpr_s | grant_fgpr_s | grant_vgpr_s | rsvd_s;

   // Grants are one-hot per file, so OR-ing the selected lanes picks the winner.
   always_comb begin
      gpr_idx_s   = 5'd0;
      fgpr_idx_s  = 5'd0;
      vgpr_idx_s  = 5'd0;
      gpr_data_s  = '0;
      fgpr_data_s = '0;
      vgpr_data_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_gpr_s[i]) begin
            gpr_idx_s  = gpr_idx_s  | req_index[5*i +: 5];
            gpr_data_s = gpr_data_s | req_data[VW*i +: DW];
         end else begin
            gpr_idx_s  = gpr_idx_s;
         end
         if (grant_fgpr_s[i]) begin
            fgpr_idx_s  = fgpr_idx_s  | req_index[5*i +: 5];
            fgpr_data_s = fgpr_data_s | req_data[VW*i +: DW];
         end else begin
            fgpr_idx_s  = fgpr_idx_s;
         end
         if (grant_vgpr_s[i]) begin
            vgpr_idx_s  = vgpr_idx_s  | req_index[5*i +: 5];
            vgpr_data_s = vgpr_data_s | req_data[VW*i +: VW];
         end else begin
            vgpr_idx_s  = vgpr_idx_s;
         end
      end
   end

   // GPR write-port register; r0 is hardwired, so its writes are accepted but dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gpr_write <= 1'b0;
         rd_index  <= 5'd0;
         data_rd   <= '0;
      end else if (|grant_gpr_s) begin
         gpr_write <= (gpr_idx_s != 5'd0);
         rd_index  <= gpr_idx_s;
         data_rd   <= gpr_data_s;
      end else begin
         gpr_write <= 1'b0;
         rd_index  <= rd_index;
         data_rd   <= data_rd;
      end
   end

   // FGPR write-port register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fgpr_write <= 1'b0;
         fd_index   <= 5'd0;
         data_fd    <= '0;
      end else if (|grant_fgpr_s) begin
         fgpr_write <= 1'b1;
         fd_index   <= fgpr_idx_s;
         data_fd    <= fgpr_data_s;
      end else begin
         fgpr_write <= 1'b0;
         fd_index   <= fd_index;
         data_fd    <= data_fd;
      end
   end

   // VGPR write-port register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vgpr_write <= 1'b0;
         vd_index   <= 5'd0;
         data_vd    <= '0;
      end else if (|grant_vgpr_s) begin
         vgpr_write <= 1'b1;
         vd_index   <= vgpr_idx_s;
         data_vd    <= vgpr_data_s;
      end else begin
         vgpr_write <= 1'b0;
         vd_index   <= vd_index;
         data_vd    <= data_vd;
      end
   end

   // Sticky flag for any accepted reserved-code request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bad_req <= 1'b0;
      end else if (|rsvd_s) begin
         bad_req <= 1'b1;
      end else begin
         bad_req <= bad_req;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter; WB_FIXED_PRIO_EN changes the last scenario's expectations.
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   localparam int NREQ = 4;
   localparam int DW   = WB_DW;
   localparam int VW   = WB_VW;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [2*NREQ-1:0]   req_file;
   logic [5*NREQ-1:0]   req_index;
   logic [VW*NREQ-1:0]  req_data;
   logic                gpr_write, fgpr_write, vgpr_write, bad_req;
   logic [4:0]          rd_index, fd_index, vd_index;
   logic [DW-1:0]       data_rd, data_fd;
   logic [VW-1:0]       data_vd;

   wb_port_arbiter #(.NREQ(NREQ), .DW(DW), .VW(VW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_file   (req_file),
      .req_index  (req_index),
      .req_data   (req_data),
      .gpr_write  (gpr_write),
      .rd_index   (rd_index),
      .data_rd    (data_rd),
      .fgpr_write (fgpr_write),
      .fd_index   (fd_index),
      .data_fd    (data_fd),
      .vgpr_write (vgpr_write),
      .vd_index   (vd_index),
      .data_vd    (data_vd),
      .bad_req    (bad_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]    idx;
      logic [VW-1:0] data;
   } wr_t;

   wr_t  q_gpr[$];
   wr_t  q_fgpr[$];
   wr_t  q_vgpr[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_bad  = 1'b0;

   task automatic check_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [1:0] f, input logic [4:0] idx, input logic [VW-1:0] d);
      req_valid[i]         = 1'b1;
      req_file[2*i +: 2]   = f;
      req_index[5*i +: 5]  = idx;
      req_data[VW*i +: VW] = d;
   endtask

   // Check ready mid-cycle and queue the writes the acceptance implies.
   task automatic accept(input logic [NREQ-1:0] exp_ready);
      wr_t e;
      @(negedge clk);
      check_val("req_ready", req_ready, exp_ready);
      for (int i = 0; i < NREQ; i++) begin
         if (exp_ready[i] && req_valid[i]) begin
            e.idx  = req_index[5*i +: 5];
            e.data = req_data[VW*i +: VW];
            case (req_file[2*i +: 2])
               WB_FILE_GPR: begin
                  e.data = {{(VW-DW){1'b0}}, e.data[DW-1:0]};
                  if (e.idx != 5'd0) q_gpr.push_back(e);
               end
               WB_FILE_FGPR: begin
                  e.data = {{(VW-DW){1'b0}}, e.data[DW-1:0]};
                  q_fgpr.push_back(e);
               end
               WB_FILE_VGPR: q_vgpr.push_back(e);
               default:      exp_bad = 1'b1;
            endcase
         end
      end
   endtask

   // After the edge, each port must show exactly the queued write or no strobe.
   task automatic settle();
      wr_t e;
      @(posedge clk);
      #1;
      if (q_gpr.size() > 0) begin
         e = q_gpr.pop_front();
         check_val("gpr_write", gpr_write, 1);
         check_val("rd_index", rd_index, e.idx);
         check_val("data_rd", data_rd, e.data);
      end else begin
         check_val("gpr_write idle", gpr_write, 0);
      end
      if (q_fgpr.size() > 0) begin
         e = q_fgpr.pop_front();
         check_val("fgpr_write", fgpr_write, 1);
         check_val("fd_index", fd_index, e.idx);
         check_val("data_fd", data_fd, e.data);
      end else begin
         check_val("fgpr_write idle", fgpr_write, 0);
      end
      if (q_vgpr.size() > 0) begin
         e = q_vgpr.pop_front();
         check_val("vgpr_write", vgpr_write, 1);
         check_val("vd_index", vd_index, e.idx);
         check_val("data_vd", data_vd, e.data);
      end else begin
         check_val("vgpr_write idle", vgpr_write, 0);
      end
      check_val("bad_req", bad_req, exp_bad);
   endtask

   task automatic step(input logic [NREQ-1:0] exp_ready);
      accept(exp_ready);
      settle();
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, " gpr_write"}, gpr_write, 0);
      check_val({tag, " fgpr_write"}, fgpr_write, 0);
      check_val({tag, " vgpr_write"}, vgpr_write, 0);
      check_val({tag, " rd_index"}, rd_index, 0);
      check_val({tag, " fd_index"}, fd_index, 0);
      check_val({tag, " vd_index"}, vd_index, 0);
      check_val({tag, " data_rd"}, data_rd, 0);
      check_val({tag, " data_fd"}, data_fd, 0);
      check_val({tag, " data_vd"}, data_vd, 0);
      check_val({tag, " bad_req"}, bad_req, 0);
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_file  = '0;
      req_index = '0;
      req_data  = '0;
      @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b1;

      // Single GPR write, then idle.
      set_req(0, WB_FILE_GPR, 5'd5, 128'h1234);
      step(4'b0001);
      req_valid = '0;
      step(4'b0000);

      // Pointer back to 0, then four competing GPR requesters drop after ready.
      rst = 1'b0;
      #1;
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, WB_FILE_GPR, 5'(i + 1), 128'h100 + 128'(i));
      step(4'b0001);
      req_valid[0] = 1'b0;
      step(4'b0010);
      req_valid[1] = 1'b0;
      step(4'b0100);
      req_valid[2] = 1'b0;
      step(4'b1000);
      req_valid[3] = 1'b0;
      step(4'b0000);

      // Three files written in the same cycle.
      set_req(0, WB_FILE_GPR,  5'd3, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0003);
      set_req(1, WB_FILE_FGPR, 5'd7, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0007);
      set_req(2, WB_FILE_VGPR, 5'd9, 128'hAAAA_5555_AAAA_5555_AAAA_AAAA_AAAA_0009);
      step(4'b0111);
      req_valid = '0;
      step(4'b0000);

      // GPR r0 accepted without a strobe; reserved code sets the sticky flag.
      set_req(3, WB_FILE_GPR, 5'd0, 128'hDEAD);
      step(4'b1000);
      req_valid = '0;
      set_req(3, WB_FILE_RSVD, 5'd4, 128'hBEEF);
      step(4'b1000);
      req_valid = '0;
      step(4'b0000);
      step(4'b0000);

      // FGPR pointer sits at 2, so the search wraps and finds req0 first.
      set_req(0, WB_FILE_FGPR, 5'd10, 128'h0A0A);
      set_req(1, WB_FILE_FGPR, 5'd11, 128'h0B0B);
      step(4'b0001);
      req_valid[0] = 1'b0;
      step(4'b0010);
      req_valid = '0;
      step(4'b0000);

      // Reserved request alongside a VGPR write.
      set_req(0, WB_FILE_VGPR, 5'd12, 128'hC0FFEE00_11223344_55667788_99AABBCC);
      set_req(3, WB_FILE_RSVD, 5'd1, 128'h1);
      step(4'b1001);
      req_valid = '0;
      step(4'b0000);

      // Reset in the middle of a GPR stream; the pending write is lost.
      set_req(0, WB_FILE_GPR, 5'd20, 128'h2020);
      set_req(1, WB_FILE_GPR, 5'd21, 128'h2121);
      step(4'b0001);
      req_valid[0] = 1'b0;
      accept(4'b0010);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q_gpr.delete();
      q_fgpr.delete();
      q_vgpr.delete();
      exp_bad = 1'b0;
      #1;
      check_zero("async reset");
      req_valid = '0;
      @(posedge clk);
      #1;
      check_zero("reset held");
      rst = 1'b1;
      set_req(1, WB_FILE_GPR, 5'd23, 128'h2323);
      set_req(0, WB_FILE_GPR, 5'd22, 128'h2222);
      step(4'b0001);

      // Two requesters holding GPR requests continuously.
`ifdef WB_FIXED_PRIO_EN
      step(4'b0001);
      step(4'b0001);
      step(4'b0001);
      step(4'b0001);
`else
      step(4'b0010);
      step(4'b0001);
      step(4'b0010);
      step(4'b0001);
`endif
      req_valid = '0;
      step(4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
